// File: rtl/vpu_pkg.sv
// Shared types and constants for the vector register-file writeback path.
package vpu_pkg;
    localparam int LANES     = 6;
    localparam int LANE_W    = 8;
    localparam int NUM_VREGS = 10;
    localparam int NUM_SREGS = 6;
    localparam int DST_W     = 4;

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    typedef struct packed {
        logic [DST_W-1:0] dst;
        vec_t             data;
        logic             sflag;
    } wb_entry_t;

    function automatic logic entry_legal(input wb_entry_t e);
        return e.sflag ? (e.dst < DST_W'(NUM_SREGS)) : (e.dst < DST_W'(NUM_VREGS));
    endfunction

    // Scalar entries all map onto busy bit 0; vector entries map onto their own register.
    function automatic logic [NUM_VREGS-1:0] busy_onehot(input logic [DST_W-1:0] dst,
                                                         input logic sflag);
        logic [NUM_VREGS-1:0] v;
        v = '0;
        for (int r = 0; r < NUM_VREGS; r++) begin
            v[r] = sflag ? (r == 0) : (dst == DST_W'(r));
        end
        return v;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head is read combinationally so a pop
// can be registered straight onto the write port.
module wb_fifo
    import vpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        din,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] rd_ptr,
    output wb_entry_t        slots [DEPTH]
);
    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: clearing the count is enough to discard entries.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign rd_ptr = rd_ptr_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slots
        assign slots[gi] = mem_q[gi];
    end
endmodule

// File: rtl/vreg_writeback.sv
// Merges load and ALU results into one ordered queue and drains it, one entry
// per cycle, onto the registered register-file write port.
module vreg_writeback
    import vpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [3:0]           mem_dst,
    input  vec_t                 mem_data,
    input  logic                 mem_sflag,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [3:0]           alu_dst,
    input  vec_t                 alu_data,
    input  logic                 alu_sflag,
    input  logic                 hold,
    output logic                 WE3,
    output logic [3:0]           A3,
    output vec_t                 WD3,
    output logic                 SFlag,
    output logic [NUM_VREGS-1:0] busy_mask,
    output logic                 err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        in_entry, head;
    wb_entry_t        slots [DEPTH];
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full, fifo_empty;
    logic             mem_fire, alu_fire, accept, push, pop;
    logic [DEPTH-1:0] occupied;

    logic       we3_q, we3_d;
    logic [3:0] a3_q, a3_d;
    vec_t       wd3_q, wd3_d;
    logic       sflag_q, sflag_d;
    logic       err_q, err_d;

    // Readiness looks only at the registered count, never at a same-cycle pop.
    assign mem_ready = !fifo_full;
    assign alu_ready = !fifo_full && !mem_valid;

    always_comb begin
        mem_fire = mem_valid && mem_ready;
        alu_fire = alu_valid && alu_ready;
        in_entry.dst   = mem_fire ? mem_dst   : alu_dst;
        in_entry.data  = mem_fire ? mem_data  : alu_data;
        in_entry.sflag = mem_fire ? mem_sflag : alu_sflag;
        accept = mem_fire || alu_fire;
        push   = accept && entry_legal(in_entry);
        err_d  = accept && !entry_legal(in_entry);
        pop    = !hold && !fifo_empty;

        we3_d   = pop;
        a3_d    = a3_q;
        wd3_d   = wd3_q;
        sflag_d = sflag_q;
        if (pop) begin
            a3_d    = head.dst;
            wd3_d   = head.data;
            sflag_d = head.sflag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q   <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
            sflag_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            sflag_q <= sflag_d;
            err_q   <= err_d;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .din    (in_entry),
        .pop    (pop),
        .head   (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .rd_ptr (rd_ptr),
        .slots  (slots)
    );

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
        logic [PTR_W-1:0] age;
        assign age          = PTR_W'(gi) - rd_ptr;
        assign occupied[gi] = ({1'b0, age} < fifo_count);
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i]) begin
                busy_mask = busy_mask | busy_onehot(slots[i].dst, slots[i].sflag);
            end
        end
        if (we3_q) begin
            busy_mask = busy_mask | busy_onehot(a3_q, sflag_q);
        end
    end

    assign WE3   = we3_q;
    assign A3    = a3_q;
    assign WD3   = wd3_q;
    assign SFlag = sflag_q;
    assign err   = err_q;
endmodule

// File: tb/tb_vreg_writeback.sv
// Bench for vreg_writeback: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vreg_writeback;
    import vpu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_valid = 1'b0, alu_valid = 1'b0, hold = 1'b0;
    logic [3:0] mem_dst = '0, alu_dst = '0;
    vec_t       mem_data = '0, alu_data = '0;
    logic       mem_sflag = 1'b0, alu_sflag = 1'b0;
    logic       mem_ready, alu_ready, WE3, SFlag, err;
    logic [3:0] A3;
    vec_t       WD3;
    logic [9:0] busy_mask;

    vreg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst),
        .mem_data(mem_data), .mem_sflag(mem_sflag),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst),
        .alu_data(alu_data), .alu_sflag(alu_sflag),
        .hold(hold), .WE3(WE3), .A3(A3), .WD3(WD3), .SFlag(SFlag),
        .busy_mask(busy_mask), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the write queue as a plain list of accepted legal entries.
    wb_entry_t  q[$];
    wb_entry_t  cand, popped;
    logic       exp_we = 0, exp_sf = 0, exp_err = 0;
    logic [3:0] exp_a3 = 0;
    vec_t       exp_wd = 0;
    bit         acc_mem = 0, acc_alu = 0, room;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_we = 0; exp_a3 = 0; exp_wd = 0; exp_sf = 0; exp_err = 0;
            acc_mem = 0; acc_alu = 0;
        end else begin
            room    = q.size() < DEPTH;
            acc_mem = mem_valid && room;
            acc_alu = alu_valid && room && !mem_valid;
            exp_err = 0;
            exp_we  = 0;
            if (!hold && q.size() > 0) begin
                popped = q.pop_front();
                exp_we = 1; exp_a3 = popped.dst; exp_wd = popped.data; exp_sf = popped.sflag;
            end
            if (acc_mem || acc_alu) begin
                cand.dst   = acc_mem ? mem_dst   : alu_dst;
                cand.data  = acc_mem ? mem_data  : alu_data;
                cand.sflag = acc_mem ? mem_sflag : alu_sflag;
                if ((cand.sflag && cand.dst < 6) || (!cand.sflag && cand.dst < 10))
                    q.push_back(cand);
                else
                    exp_err = 1;
            end
        end
    end

    function automatic logic [9:0] model_busy();
        logic [9:0] b;
        b = '0;
        foreach (q[k]) b[q[k].sflag ? 4'd0 : q[k].dst] = 1'b1;
        if (exp_we) b[exp_sf ? 4'd0 : exp_a3] = 1'b1;
        return b;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_we3", WE3, exp_we);
            check("m_a3", A3, exp_a3);
            check("m_wd3", WD3, exp_wd);
            check("m_sflag", SFlag, exp_sf);
            check("m_err", err, exp_err);
            check("m_busy", busy_mask, model_busy());
            check("m_mem_ready", mem_ready, q.size() < DEPTH);
            check("m_alu_ready", alu_ready, (q.size() < DEPTH) && !mem_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Offer one entry on a source and hold it until the model sees it accepted.
    task automatic send(input bit use_mem, input logic [3:0] d, input vec_t v, input logic s);
        int k;
        if (use_mem) begin mem_valid = 1; mem_dst = d; mem_data = v; mem_sflag = s; end
        else         begin alu_valid = 1; alu_dst = d; alu_data = v; alu_sflag = s; end
        for (k = 0; k < 20; k++) begin
            step();
            if (use_mem ? acc_mem : acc_alu) break;
        end
        if (k == 20) check("send_timeout", 1, 0);
        mem_valid = 0;
        alu_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        rst = 0;
        #1;
        chk_en = 1;
        check("rst_we3", WE3, 0);
        check("rst_a3", A3, 0);
        check("rst_wd3", WD3, 0);
        check("rst_sflag", SFlag, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_err", err, 0);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_alu_ready", alu_ready, 1);
        mem_valid = 1; mem_dst = 4'd15; mem_sflag = 0;
        #1;
        check("rst_alu_ready_mv", alu_ready, 0);
        mem_valid = 0;
        step();

        // Single vector write
        send(1, 4'd7, 48'h010203040506, 0);
        check("v_we3_early", WE3, 0);
        check("v_busy1", busy_mask, 10'h080);
        step();
        check("v_we3", WE3, 1);
        check("v_a3", A3, 7);
        check("v_wd3", WD3, 48'h010203040506);
        check("v_sflag", SFlag, 0);
        check("v_busy2", busy_mask, 10'h080);
        step();
        check("v_we3_off", WE3, 0);
        check("v_busy3", busy_mask, 0);

        // Priority: both valid on the same edge
        mem_valid = 1; mem_dst = 4'd2; mem_data = 48'h111111111111; mem_sflag = 0;
        alu_valid = 1; alu_dst = 4'd5; alu_data = 48'h222222222222; alu_sflag = 0;
        #1;
        check("pri_alu_ready", alu_ready, 0);
        step();
        check("pri_mem_acc", acc_mem, 1);
        mem_valid = 0;
        step();
        alu_valid = 0;
        check("pri_first_a3", A3, 2);
        check("pri_first_we", WE3, 1);
        step();
        check("pri_second_a3", A3, 5);
        check("pri_second_wd", WD3, 48'h222222222222);
        step();

        // Full queue under hold, then release
        hold = 1;
        for (int i = 1; i <= 4; i++) send(1, 4'(i), vec_t'(48'h0A0A0A0A0A00 + 48'(i)), 0);
        check("full_mem_ready", mem_ready, 0);
        check("full_busy", busy_mask, 10'h01E);
        mem_valid = 1; mem_dst = 4'd5; mem_data = 48'h0A0A0A0A0A05; mem_sflag = 0;
        step();
        step();
        check("stall_ready", mem_ready, 0);
        check("stall_we3", WE3, 0);
        hold = 0;
        step();
        check("rel_we1", WE3, 1);
        check("rel_a3_1", A3, 1);
        check("rel_ready_up", mem_ready, 1);
        step();
        check("rel_acc5", acc_mem, 1);
        mem_valid = 0;
        check("rel_a3_2", A3, 2);
        for (int i = 3; i <= 5; i++) begin
            step();
            check("rel_we_n", WE3, 1);
            check("rel_a3_n", A3, 4'(i));
        end
        step();
        check("rel_done", WE3, 0);

        // Illegal destinations
        send(0, 4'd8, 48'h333333333333, 1);
        check("ill_s_err", err, 1);
        check("ill_s_busy", busy_mask, 0);
        step();
        check("ill_s_err_off", err, 0);
        check("ill_s_we3", WE3, 0);
        send(0, 4'd10, 48'h444444444444, 0);
        check("ill_v_err", err, 1);
        step();
        check("ill_v_we3", WE3, 0);

        // Scalar write
        send(0, 4'd3, 48'h0000000000AB, 1);
        check("sc_busy", busy_mask, 10'h001);
        step();
        check("sc_we3", WE3, 1);
        check("sc_a3", A3, 3);
        check("sc_sflag", SFlag, 1);
        check("sc_lane0", WD3[0], 8'hAB);
        step();

        // Mixed directed stream with some illegal entries and a hold cycle
        for (int i = 0; i < 8; i++) begin
            hold = (i == 4);
            send(i % 2 == 0, 4'((i * 3) % 11), vec_t'(48'h010101010101 * 48'(i + 1)), (i % 3) == 0);
        end
        hold = 0;
        for (int i = 0; i < 6; i++) step();

        // Reset in the middle of a drain
        hold = 1;
        for (int i = 1; i <= 3; i++) send(1, 4'(i + 5), vec_t'(48'hC0C0C0C0C0C0 + 48'(i)), 0);
        hold = 0;
        step();
        check("mr_we3_before", WE3, 1);
        rst = 1;
        #1;
        check("mr_we3_async", WE3, 0);
        check("mr_busy_async", busy_mask, 0);
        step();
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mr_no_write", WE3, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
